barrier_gate_ctrl: RTL and testbench

//   Downstream of the parking occupancy FSM: takes its door_open request and drives the

---
 rtl/parking_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/barrier_gate_ctrl.sv | 161 ++++++++++++++++
 tb/tb_barrier_gate_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-gate control blocks.
//   gate_state_t         : barrier controller state encoding
//   DEFAULT_MOVE_TIMEOUT : max cycles of motor travel before a limit switch must be seen
//   DEFAULT_DWELL_CYCLES : cycles the gate stays open with a clear beam before lowering
package parking_pkg;

  typedef enum logic [2:0] {
    CLOSED   = 3'd0,
    RAISING  = 3'd1,
    OPEN     = 3'd2,
    LOWERING = 3'd3,
    FAULT    = 3'd4
  } gate_state_t;

  localparam int unsigned DEFAULT_MOVE_TIMEOUT = 1000;
  localparam int unsigned DEFAULT_DWELL_CYCLES = 500;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears both stages
//   d       : raw asynchronous inputs
//   q       : synchronised outputs, two cycles of latency
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/barrier_gate_ctrl.sv
// Barrier motor controller: turns the occupancy FSM's door_open request into
// raise/hold/lower motor drive, closes the loop on the limit switches and the
// in-gate beam, reverses on obstruction, faults on motor timeout or
// inconsistent switches, and counts vehicles passing under the barrier.
//   clk, reset_n           : clock, asynchronous active-low reset
//   door_open              : open request, level
//   limit_up, limit_down   : raw limit switches (synchronised here)
//   obstruct               : raw in-gate beam (synchronised here)
//   fault_clr              : leave FAULT
//   motor_up, motor_down   : motor drive
//   gate_closed, gate_fault: state flags
//   pass_count             : vehicles passed, mod 256
module barrier_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned MOVE_TIMEOUT = DEFAULT_MOVE_TIMEOUT,
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       door_open,
  input  logic       limit_up,
  input  logic       limit_down,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_down,
  output logic       gate_closed,
  output logic       gate_fault,
  output logic [7:0] pass_count
);

  localparam logic [TIMER_W-1:0] MoveLast  = TIMER_W'(MOVE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DwellLast = TIMER_W'(DWELL_CYCLES - 1);

  logic [2:0] sync_out;
  logic       lu, ld, ob;
  logic       ob_d;

  gate_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pass_inc;

  sync_2ff #(
    .WIDTH (3)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({obstruct, limit_down, limit_up}),
    .q       (sync_out)
  );

  assign lu = sync_out[0];
  assign ld = sync_out[1];
  assign ob = sync_out[2];

  // State register and timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLOSED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q != FAULT && lu && ld) begin
      // Both limit switches closed at once cannot happen on a healthy gate.
      state_d = FAULT;
      timer_d = '0;
    end else begin
      unique case (state_q)
        CLOSED: begin
          if (door_open) begin
            state_d = RAISING;
            timer_d = '0;
          end
        end
        RAISING: begin
          if (lu) begin
            state_d = OPEN;
            timer_d = '0;
          end else if (timer_q == MoveLast) begin
            state_d = FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        OPEN: begin
          if (ob || door_open) begin
            timer_d = '0;
          end else if (timer_q == DwellLast) begin
            state_d = LOWERING;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        LOWERING: begin
          // Safety reversal takes priority over reaching the down switch.
          if (ob || door_open) begin
            state_d = RAISING;
            timer_d = '0;
          end else if (ld) begin
            state_d = CLOSED;
            timer_d = '0;
          end else if (timer_q == MoveLast) begin
            state_d = FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state_d = ld ? CLOSED : RAISING;
            timer_d = '0;
          end
        end
        default: begin
          state_d = FAULT;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    motor_up    = (state_q == RAISING);
    motor_down  = (state_q == LOWERING);
    gate_closed = (state_q == CLOSED);
    gate_fault  = (state_q == FAULT);
  end

  // A vehicle has passed once the beam clears again.
  assign pass_inc = ob_d && !ob && (state_q != FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ob_d       <= 1'b0;
      pass_count <= 8'd0;
    end else begin
      ob_d <= ob;
      if (pass_inc) begin
        pass_count <= pass_count + 8'd1;
      end
    end
  end

  motor_exclusive_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(motor_up && motor_down));

endmodule

// File: tb/tb_barrier_gate_ctrl.sv
module tb_barrier_gate_ctrl;

  logic       clk;
  logic       reset_n;
  logic       door_open;
  logic       limit_up;
  logic       limit_down;
  logic       obstruct;
  logic       fault_clr;
  logic       motor_up;
  logic       motor_down;
  logic       gate_closed;
  logic       gate_fault;
  logic [7:0] pass_count;

  barrier_gate_ctrl #(
    .TIMER_W      (16),
    .MOVE_TIMEOUT (16),
    .DWELL_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .door_open   (door_open),
    .limit_up    (limit_up),
    .limit_down  (limit_down),
    .obstruct    (obstruct),
    .fault_clr   (fault_clr),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .gate_closed (gate_closed),
    .gate_fault  (gate_fault),
    .pass_count  (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index, counts rising edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic       mu;
    logic       md;
    logic       gc;
    logic       gf;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input string nm, input logic mu, input logic md,
                           input logic gc, input logic gf, input logic [7:0] pc);
    exp_t e;
    e.cyc = cyc + dly;
    e.nm  = nm;
    e.mu  = mu;
    e.md  = md;
    e.gc  = gc;
    e.gf  = gf;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.nm, cyc, e.cyc);
      end else if ({motor_up, motor_down, gate_closed, gate_fault} !== {e.mu, e.md, e.gc, e.gf}
                   || pass_count !== e.pc) begin
        $display("FAIL %s: got up=%b dn=%b closed=%b fault=%b count=%0d, required up=%b dn=%b closed=%b fault=%b count=%0d",
                 e.nm, motor_up, motor_down, gate_closed, gate_fault, pass_count,
                 e.mu, e.md, e.gc, e.gf, e.pc);
      end else begin
        passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             passes, checks);
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    door_open  = 1'b0;
    limit_up   = 1'b0;
    limit_down = 1'b0;
    obstruct   = 1'b0;
    fault_clr  = 1'b0;
    tick(2);
    expect_at(0, "reset", 0, 0, 1, 0, 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // 1: normal cycle
    door_open = 1'b1;
    expect_at(1, "t1_raise", 1, 0, 0, 0, 0);
    tick(1);
    door_open = 1'b0;
    tick(4);
    limit_up = 1'b1;
    expect_at(2,  "t1_raise_last", 1, 0, 0, 0, 0);
    expect_at(3,  "t1_open",       0, 0, 0, 0, 0);
    expect_at(10, "t1_dwell_last", 0, 0, 0, 0, 0);
    expect_at(11, "t1_lower",      0, 1, 0, 0, 0);
    tick(11);
    limit_up = 1'b0;
    tick(4);
    limit_down = 1'b1;
    expect_at(2, "t1_lower_last", 0, 1, 0, 0, 0);
    expect_at(3, "t1_closed",     0, 0, 1, 0, 0);
    tick(3);

    // 2: obstruction reversal and pass count
    door_open  = 1'b1;
    limit_down = 1'b0;
    expect_at(1, "t2_raise", 1, 0, 0, 0, 0);
    tick(1);
    door_open = 1'b0;
    limit_up  = 1'b1;
    expect_at(3,  "t2_open",  0, 0, 0, 0, 0);
    expect_at(11, "t2_lower", 0, 1, 0, 0, 0);
    tick(11);
    limit_up = 1'b0;
    tick(2);
    obstruct = 1'b1;
    expect_at(2, "t2_still_lower", 0, 1, 0, 0, 0);
    expect_at(3, "t2_reverse",     1, 0, 0, 0, 0);
    tick(3);
    obstruct = 1'b0;
    expect_at(2, "t2_count_before", 1, 0, 0, 0, 0);
    expect_at(3, "t2_count_after",  1, 0, 0, 0, 1);
    tick(3);
    limit_up = 1'b1;
    expect_at(3, "t2_reopen", 0, 0, 0, 0, 1);
    tick(4);
    limit_up = 1'b0;
    expect_at(7, "t2_relower", 0, 1, 0, 0, 1);
    tick(7);
    limit_down = 1'b1;
    expect_at(3, "t2_closed", 0, 0, 1, 0, 1);
    tick(3);

    // 3: raise timeout, fault hold, clear with the gate down
    door_open  = 1'b1;
    limit_down = 1'b0;
    expect_at(16, "t3_raise_last", 1, 0, 0, 0, 1);
    expect_at(17, "t3_fault",      0, 0, 0, 1, 1);
    tick(1);
    door_open = 1'b0;
    tick(16);
    door_open = 1'b1;
    expect_at(3, "t3_fault_hold", 0, 0, 0, 1, 1);
    tick(3);
    door_open  = 1'b0;
    limit_down = 1'b1;
    tick(2);
    fault_clr = 1'b1;
    expect_at(1, "t3_cleared", 0, 0, 1, 0, 1);
    tick(1);
    fault_clr = 1'b0;

    // 4: dwell restart by beam pulses at dwell counts 5 and 7
    door_open  = 1'b1;
    limit_down = 1'b0;
    tick(1);
    door_open = 1'b0;
    limit_up  = 1'b1;
    expect_at(3, "t4_open", 0, 0, 0, 0, 1);
    tick(3);
    limit_up = 1'b0;
    tick(3);
    obstruct = 1'b1;
    tick(1);
    obstruct = 1'b0;
    tick(7);
    obstruct = 1'b1;
    expect_at(3,  "t4_no_early_lower", 0, 0, 0, 0, 2);
    expect_at(10, "t4_dwell_last",     0, 0, 0, 0, 3);
    expect_at(11, "t4_lower",          0, 1, 0, 0, 3);
    tick(1);
    obstruct = 1'b0;
    tick(10);
    limit_down = 1'b1;
    expect_at(3, "t4_closed", 0, 0, 1, 0, 3);
    tick(3);

    // 5: asynchronous reset while raising
    door_open  = 1'b1;
    limit_down = 1'b0;
    expect_at(1, "t5_raise", 1, 0, 0, 0, 3);
    tick(1);
    door_open = 1'b0;
    tick(2);
    #2;
    reset_n = 1'b0;
    expect_at(0, "t5_reset_mid_raise", 0, 0, 1, 0, 0);
    tick(1);
    reset_n = 1'b1;
    limit_down = 1'b1;
    tick(3);

    // 6: door_open held, counter wrap, switch inconsistency, clear with the gate up
    door_open  = 1'b1;
    limit_down = 1'b0;
    expect_at(1, "t6_raise", 1, 0, 0, 0, 0);
    tick(1);
    limit_up = 1'b1;
    expect_at(3, "t6_open", 0, 0, 0, 0, 0);
    tick(3);
    tick(20);
    expect_at(0, "t6_hold_open", 0, 0, 0, 0, 0);
    for (int i = 0; i < 255; i++) begin
      obstruct = 1'b1;
      tick(2);
      obstruct = 1'b0;
      tick(2);
    end
    tick(2);
    expect_at(0, "t6_count_255", 0, 0, 0, 0, 8'd255);
    obstruct = 1'b1;
    tick(2);
    obstruct = 1'b0;
    tick(2);
    tick(2);
    expect_at(0, "t6_count_wrap", 0, 0, 0, 0, 8'd0);
    limit_down = 1'b1;
    expect_at(2, "t6_open_pre_fault", 0, 0, 0, 0, 0);
    expect_at(3, "t6_inconsistent",   0, 0, 0, 1, 0);
    tick(3);
    door_open  = 1'b0;
    limit_up   = 1'b0;
    limit_down = 1'b0;
    tick(3);
    fault_clr = 1'b1;
    expect_at(1, "t6_clear_raise", 1, 0, 0, 0, 0);
    tick(1);
    fault_clr = 1'b0;
    tick(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
